// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide sequencer holding HI/LO beside the E-stage ALU.
// Define MD_MADD_EN to enable the accumulate ops madd/maddu/msub/msubu (op codes 6..9).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, rhi_q, rlo_q;

  logic [63:0]   prod_s_s, prod_u_s, res_d;
  logic [CW-1:0] cnt_d;
  logic [31:0]   a_mag_s, b_mag_s, b_div_s, b_u_s;
  logic [31:0]   q_mag_s, r_mag_s, sq_s, sr_s, uq_s, ur_s;

  function automatic logic is_long_op(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd2, 4'd3: is_long_op = 1'b1;
`ifdef MD_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: is_long_op = 1'b1;
`endif
      default:                is_long_op = 1'b0;
    endcase
  endfunction

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0.
  assign a_mag_s = a[31] ? (32'd0 - a) : a;
  assign b_mag_s = b[31] ? (32'd0 - b) : b;
  assign b_div_s = (b == 32'd0) ? 32'd1 : b_mag_s;
  assign b_u_s   = (b == 32'd0) ? 32'd1 : b;
  assign q_mag_s = a_mag_s / b_div_s;
  assign r_mag_s = a_mag_s % b_div_s;
  assign sq_s    = (a[31] ^ b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
  assign sr_s    = a[31] ? (32'd0 - r_mag_s) : r_mag_s;
  assign uq_s    = a / b_u_s;
  assign ur_s    = a % b_u_s;

  always_comb begin
    res_d = {hi_q, lo_q};
    cnt_d = CW'(MULT_CYCLES);
    case (op)
      4'd0: res_d = prod_s_s;
      4'd1: res_d = prod_u_s;
      4'd2: begin
        cnt_d = CW'(DIV_CYCLES);
        if (b != 32'd0) res_d = {sr_s, sq_s};
        else            res_d = {hi_q, lo_q};
      end
      4'd3: begin
        cnt_d = CW'(DIV_CYCLES);
        if (b != 32'd0) res_d = {ur_s, uq_s};
        else            res_d = {hi_q, lo_q};
      end
`ifdef MD_MADD_EN
      4'd6: res_d = {hi_q, lo_q} + prod_s_s;
      4'd7: res_d = {hi_q, lo_q} + prod_u_s;
      4'd8: res_d = {hi_q, lo_q} - prod_s_s;
      4'd9: res_d = {hi_q, lo_q} - prod_u_s;
`endif
      default: res_d = {hi_q, lo_q};
    endcase
  end

  // Result is computed at the start edge and parked in the shadow until the window closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rhi_q   <= 32'd0;
      rlo_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && is_long_op(op)) begin
            {rhi_q, rlo_q} <= res_d;
            cnt_q          <= cnt_d;
            state_q        <= ST_RUN;
          end else if (start && (op == 4'd4)) begin
            hi_q <= a;
          end else if (start && (op == 4'd5)) begin
            lo_q <= a;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= rhi_q;
            lo_q    <= rlo_q;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = d_md & (busy | (start & (op != 4'd4) & (op != 4'd5)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and randomized checks of md_sched against a 64-bit arithmetic model.
// Build with +define+MD_MADD_EN to expect the accumulate ops to be active.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, d_md;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_md(d_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  function automatic int ref_latency(input logic [3:0] o);
    if (o <= 4'd1) return MULT_N;
    if (o <= 4'd3) return DIV_N;
    if (o >= 4'd6 && o <= 4'd9 && MADD) return MULT_N;
    return 0;
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x, y,
                                             input logic [31:0] h, l);
    longint sx, sy;
    longint unsigned ux, uy, cur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    cur = {h, l};
    case (o)
      4'd0: return sx * sy;
      4'd1: return ux * uy;
      4'd2: return (y == 32'd0) ? cur : {32'(sx % sy), 32'(sx / sy)};
      4'd3: return (y == 32'd0) ? cur : {32'(ux % uy), 32'(ux / uy)};
      4'd4: return {x, l};
      4'd5: return {h, x};
      4'd6: return MADD ? cur + 64'(sx * sy) : cur;
      4'd7: return MADD ? cur + ux * uy : cur;
      4'd8: return MADD ? cur - 64'(sx * sy) : cur;
      4'd9: return MADD ? cur - ux * uy : cur;
      default: return cur;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts busy cycles after a start edge; capped so a stuck busy cannot hang the run.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; d_md = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests_run++; if ({hi, lo} !== 64'd0) begin tests_failed++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    d_md = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    int n;
    do_op(4'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(n);
    tests_run++; if (n != MULT_N) begin tests_failed++; $display("FAIL mult_latency: got %0d expected %0d", n, MULT_N); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_div;
    int n;
    do_op(4'd3, 32'd100, 32'd7);
    wait_done(n);
    tests_run++; if (n != DIV_N) begin tests_failed++; $display("FAIL divu_latency: got %0d expected %0d", n, DIV_N); end
    tests_run++; if ({hi, lo} !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL divu_result: got %h expected 000000020000000e", {hi, lo}); end
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    tests_run++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin tests_failed++; $display("FAIL div_neg: got %h expected fffffffffffffffd", {hi, lo}); end
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    tests_run++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin tests_failed++; $display("FAIL div_ovf: got %h expected 0000000080000000", {hi, lo}); end
    m_hi = 32'd0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_div_zero;
    int n;
    do_op(4'd4, 32'h1234, 32'd0);
    do_op(4'd5, 32'h1234, 32'd0);
    do_op(4'd2, 32'd5, 32'd0);
    wait_done(n);
    tests_run++; if (n != DIV_N) begin tests_failed++; $display("FAIL divzero_latency: got %0d expected %0d", n, DIV_N); end
    tests_run++; if ({hi, lo} !== {32'h1234, 32'h1234}) begin tests_failed++; $display("FAIL divzero_hilo: got %h expected 0000123400001234", {hi, lo}); end
    m_hi = 32'h1234; m_lo = 32'h1234;
  endtask

  task automatic test_stall;
    int n, errs;
    d_md = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL stall_start: got %b expected 1", stall); end
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; errs = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      if (stall !== 1'b1) errs++;
      n++;
      @(negedge clk);
    end
    tests_run++; if (errs != 0 || n != MULT_N) begin tests_failed++; $display("FAIL stall_window: %0d low cycles in %0d busy cycles, expected 0 in %0d", errs, n, MULT_N); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL stall_after: got %b expected 0", stall); end
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'hDEAD; b = 32'd0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL stall_mthi: got %b expected 0", stall); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tests_run++; if (hi !== 32'hDEAD || busy !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL mthi: hi=%h busy=%b stall=%b expected hi=0000dead busy=0 stall=0", hi, busy, stall); end
    d_md = 1'b0;
    m_hi = 32'hDEAD; m_lo = 32'd12;
    tests_run++; if (lo !== m_lo) begin tests_failed++; $display("FAIL mthi_lo: got %h expected %h", lo, m_lo); end
  endtask

  task automatic test_start_while_busy;
    int n;
    do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'h5555;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    tests_run++; if (n != MULT_N - 1) begin tests_failed++; $display("FAIL busy_ignore_latency: got %0d expected %0d", n, MULT_N - 1); end
    tests_run++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFE}) begin tests_failed++; $display("FAIL busy_ignore_hilo: got %h expected 00000001fffffffe", {hi, lo}); end
    m_hi = 32'd1; m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_reset_midop;
    do_op(4'd4, 32'hAAAA, 32'd0);
    do_op(4'd5, 32'hBBBB, 32'd0);
    do_op(4'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    repeat (12) @(negedge clk);
    tests_run++; if ({hi, lo} !== 64'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_hilo: got %h busy=%b expected 0 busy=0", {hi, lo}, busy); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_madd;
    int n;
    logic [63:0] exp_v;
    do_op(4'd4, 32'd0, 32'd0);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd0);
    do_op(4'd7, 32'd1, 32'd1);
    wait_done(n);
    exp_v = MADD ? {32'd1, 32'd0} : {32'd0, 32'hFFFF_FFFF};
    tests_run++; if (n != ref_latency(4'd7)) begin tests_failed++; $display("FAIL maddu_latency: got %0d expected %0d", n, ref_latency(4'd7)); end
    tests_run++; if ({hi, lo} !== exp_v) begin tests_failed++; $display("FAIL maddu_hilo: got %h expected %h", {hi, lo}, exp_v); end
    m_hi = exp_v[63:32]; m_lo = exp_v[31:0];
  endtask

  task automatic test_random;
    int n, lat;
    logic [3:0] o;
    logic [31:0] x, y;
    logic [63:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFF_FFFF;
      exp_v = ref_result(o, x, y, m_hi, m_lo);
      lat = ref_latency(o);
      do_op(o, x, y);
      wait_done(n);
      tests_run++;
      if (n != lat || {hi, lo} !== exp_v) begin
        tests_failed++;
        $display("FAIL rand_op%0d: op=%0d a=%h b=%h got lat=%0d hilo=%h expected lat=%0d hilo=%h",
                 i, o, x, y, n, {hi, lo}, lat, exp_v);
      end
      m_hi = exp_v[63:32]; m_lo = exp_v[31:0];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_stall;
    test_start_while_busy;
    test_reset_midop;
    test_madd;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
